// File: rtl/it_sequencer_if.sv
// Decode-slot handshake between the decoder and the IT sequencer.
// The master drives the slot and control inputs; the slave returns ITSTATE and the slot condition.
interface it_sequencer_if;
   logic       instr_valid;
   logic       stall;
   logic       is_it;
   logic [3:0] it_firstcond;
   logic [3:0] it_mask;
   logic       flush;
   logic       restore_valid;
   logic [7:0] restore_state;
   logic [3:0] cond;
   logic       in_it;
   logic       it_last;
   logic [7:0] it_state;
   logic       it_err;

   modport master (
      output instr_valid, stall, is_it, it_firstcond, it_mask,
      output flush, restore_valid, restore_state,
      input  cond, in_it, it_last, it_state, it_err
   );

   modport slave (
      input  instr_valid, stall, is_it, it_firstcond, it_mask,
      input  flush, restore_valid, restore_state,
      output cond, in_it, it_last, it_state, it_err
   );
endinterface

// File: rtl/it_sequencer.sv
// IT-block sequencer: holds the 8-bit ITSTATE and supplies the condition code
// for the instruction currently in the decode slot.
module it_sequencer #(
   parameter logic [3:0] COND_AL = 4'b1110
) (
   input logic           clk,
   input logic           reset,
   it_sequencer_if.slave bus
);

   logic [7:0] itstate_q, itstate_d;
   logic       err_q, err_d;
   logic       issue;
   logic       in_it;
   logic       illegal;

   assign issue = bus.instr_valid & ~bus.stall;
   assign in_it = (itstate_q[3:0] != 4'b0000);

   assign illegal = in_it
                  | (bus.it_mask == 4'b0000)
                  | (bus.it_firstcond == 4'b1111)
                  | ((bus.it_firstcond == 4'b1110) & ~$onehot(bus.it_mask));

   always_comb begin
      itstate_d = itstate_q;
      err_d     = 1'b0;
      if (bus.flush) begin
         itstate_d = 8'h00;
      end else if (bus.restore_valid) begin
         itstate_d = bus.restore_state;
      end else if (issue) begin
         if (bus.is_it & ~illegal) begin
            itstate_d = {bus.it_firstcond, bus.it_mask};
         end else begin
            // Reaching here with is_it set means the IT was illegal.
            err_d = bus.is_it;
            if (in_it) begin
               if (itstate_q[2:0] == 3'b000) begin
                  itstate_d = 8'h00;
               end else begin
                  itstate_d = {itstate_q[7:5], itstate_q[3:0], 1'b0};
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         itstate_q <= 8'h00;
         err_q     <= 1'b0;
      end else begin
         itstate_q <= itstate_d;
         err_q     <= err_d;
      end
   end

   assign bus.cond     = in_it ? itstate_q[7:4] : COND_AL;
   assign bus.in_it    = in_it;
   assign bus.it_last  = in_it & (itstate_q[2:0] == 3'b000);
   assign bus.it_state = itstate_q;
   assign bus.it_err   = err_q;

endmodule

// File: tb/tb_it_sequencer.sv
// Self-checking bench for it_sequencer: directed test-plan scenarios plus random
// traffic, compared against a block-position model of the IT sequence.
module tb_it_sequencer;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;

   it_sequencer_if bus ();

   it_sequencer #(.COND_AL(4'b1110)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: a block is firstcond + mask, a count of instructions and a position.
   logic [3:0] m_fc;
   logic [3:0] m_mask;
   int         m_pos;
   int         m_len;
   logic       m_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic int blk_len(input logic [3:0] mk);
      if (mk[0]) return 4;
      if (mk[1]) return 3;
      if (mk[2]) return 2;
      if (mk[3]) return 1;
      return 0;
   endfunction

   function automatic logic [7:0] m_state();
      logic [4:0] t;
      if (m_len == 0) return 8'h00;
      t = 5'({m_fc[0], m_mask} << m_pos);
      return {m_fc[3:1], t};
   endfunction

   function automatic logic [3:0] m_cond();
      if (m_len == 0) return 4'b1110;
      if (m_pos == 0) return m_fc;
      return {m_fc[3:1], m_mask[4 - m_pos]};
   endfunction

   task automatic model_reset();
      m_fc = '0; m_mask = '0; m_pos = 0; m_len = 0; m_err = 1'b0;
   endtask

   task automatic model_step(input logic v, input logic st, input logic it,
                             input logic [3:0] fc, input logic [3:0] mk,
                             input logic fl, input logic rv, input logic [7:0] rs);
      logic iss, inb, ill, e;
      iss = v & ~st;
      inb = (m_len != 0);
      ill = inb || (mk == 4'h0) || (fc == 4'hF) || (fc == 4'hE && $countones(mk) != 1);
      e   = 1'b0;
      if (fl) begin
         m_len = 0; m_pos = 0;
      end else if (rv) begin
         m_fc = rs[7:4]; m_mask = rs[3:0]; m_pos = 0; m_len = blk_len(rs[3:0]);
      end else if (iss) begin
         if (it && !ill) begin
            m_fc = fc; m_mask = mk; m_pos = 0; m_len = blk_len(mk);
         end else begin
            if (it) e = 1'b1;
            if (inb) begin
               m_pos++;
               if (m_pos == m_len) begin
                  m_len = 0; m_pos = 0;
               end
            end
         end
      end
      m_err = e;
   endtask

   task automatic compare_model();
      check("cond", 32'(bus.cond), 32'(m_cond()));
      check("in_it", 32'(bus.in_it), 32'(m_len != 0));
      check("it_last", 32'(bus.it_last), 32'(m_len != 0 && m_pos == m_len - 1));
      check("it_state", 32'(bus.it_state), 32'(m_state()));
      check("it_err", 32'(bus.it_err), 32'(m_err));
   endtask

   // One clock: compare at negedge, drive, step the model at the posedge, return 1 ns after it.
   task automatic cyc(input logic v, input logic st, input logic it,
                      input logic [3:0] fc, input logic [3:0] mk,
                      input logic fl, input logic rv, input logic [7:0] rs);
      @(negedge clk);
      compare_model();
      bus.instr_valid   = v;
      bus.stall         = st;
      bus.is_it         = it;
      bus.it_firstcond  = fc;
      bus.it_mask       = mk;
      bus.flush         = fl;
      bus.restore_valid = rv;
      bus.restore_state = rs;
      @(posedge clk);
      model_step(v, st, it, fc, mk, fl, rv, rs);
      #1;
   endtask

   task automatic issue_it(input logic [3:0] fc, input logic [3:0] mk);
      cyc(1'b1, 1'b0, 1'b1, fc, mk, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic issue_plain();
      cyc(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      model_reset();
      reset = 1'b1;
      bus.instr_valid = 1'b0; bus.stall = 1'b0; bus.is_it = 1'b0;
      bus.it_firstcond = 4'h0; bus.it_mask = 4'h0; bus.flush = 1'b0;
      bus.restore_valid = 1'b0; bus.restore_state = 8'h00;
      #12;
      check("rst_state", 32'(bus.it_state), 32'h00);
      check("rst_cond", 32'(bus.cond), 32'hE);
      check("rst_in_it", 32'(bus.in_it), 32'h0);
      check("rst_last", 32'(bus.it_last), 32'h0);
      check("rst_err", 32'(bus.it_err), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      // ITTE EQ
      issue_it(4'b0000, 4'b0110);
      check("itte_s0", 32'(bus.it_state), 32'h06);
      check("itte_c0", 32'(bus.cond), 32'h0);
      check("itte_l0", 32'(bus.it_last), 32'h0);
      issue_plain();
      check("itte_s1", 32'(bus.it_state), 32'h0C);
      check("itte_c1", 32'(bus.cond), 32'h0);
      issue_plain();
      check("itte_s2", 32'(bus.it_state), 32'h18);
      check("itte_c2", 32'(bus.cond), 32'h1);
      check("itte_l2", 32'(bus.it_last), 32'h1);
      issue_plain();
      check("itte_s3", 32'(bus.it_state), 32'h00);
      check("itte_c3", 32'(bus.cond), 32'hE);

      // IT NE held by a stall
      issue_it(4'b0001, 4'b1000);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'h00);
         check("stall_s", 32'(bus.it_state), 32'h18);
         check("stall_c", 32'(bus.cond), 32'h1);
      end
      issue_plain();
      check("stall_end", 32'(bus.it_state), 32'h00);

      // Flush mid-block, coinciding with an issue
      issue_it(4'b1100, 4'b0001);
      check("gt_s0", 32'(bus.it_state), 32'hC1);
      issue_plain();
      issue_plain();
      cyc(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 8'h00);
      check("flush_in_it", 32'(bus.in_it), 32'h0);
      check("flush_cond", 32'(bus.cond), 32'hE);

      // Illegal firstcond
      issue_it(4'b1111, 4'b1000);
      check("ill_err", 32'(bus.it_err), 32'h1);
      check("ill_state", 32'(bus.it_state), 32'h00);
      check("ill_cond", 32'(bus.cond), 32'hE);
      idle();
      check("ill_err_clr", 32'(bus.it_err), 32'h0);

      // IT inside an IT block
      issue_it(4'b0000, 4'b0110);
      issue_it(4'b0001, 4'b1000);
      check("nest_state", 32'(bus.it_state), 32'h0C);
      check("nest_err", 32'(bus.it_err), 32'h1);
      issue_plain();
      issue_plain();
      check("nest_done", 32'(bus.it_state), 32'h00);

      // Restore, then restore against flush
      cyc(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 8'h2C);
      check("rest_in_it", 32'(bus.in_it), 32'h1);
      check("rest_cond", 32'(bus.cond), 32'h2);
      issue_plain();
      check("rest_next", 32'(bus.it_state), 32'h38);
      cyc(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 8'h2C);
      check("fl_vs_rest", 32'(bus.it_state), 32'h00);

      // Asynchronous reset in the middle of a block
      issue_it(4'b0000, 4'b0110);
      check("ar_pre", 32'(bus.it_state), 32'h06);
      #2;
      reset = 1'b1;
      #1;
      check("ar_state", 32'(bus.it_state), 32'h00);
      check("ar_cond", 32'(bus.cond), 32'hE);
      model_reset();
      @(negedge clk);
      bus.instr_valid = 1'b0; bus.is_it = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic v, st, it, fl, rv;
         logic [3:0] fc, mk;
         logic [7:0] rs;
         v  = ($urandom_range(0, 3) != 0);
         st = ($urandom_range(0, 4) == 0);
         it = ($urandom_range(0, 2) == 0);
         fc = 4'($urandom);
         mk = 4'($urandom);
         fl = ($urandom_range(0, 24) == 0);
         rv = ($urandom_range(0, 19) == 0);
         rs = 8'($urandom);
         if (rs[3:0] == 4'h0) rs = 8'h00;
         cyc(v, st, it, fc, mk, fl, rv, rs);
      end
      @(negedge clk);
      compare_model();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
